// File: rtl/keypad_entry.sv
// Keypad front end: sync, debounce and single-shot press detect feeding a BCD entry buffer.
// Latency: key_pulse 2+DEBOUNCE_CYCLES cycles after a key_data change; buffer outputs one cycle later.
// Backpressure: none; every accepted press is acted on, and downstream must take entry_valid when it pulses.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int MAX_DIGITS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              key_data,
    output logic                    key_pulse,
    output logic [3:0]              key_code,
    output logic [4*MAX_DIGITS-1:0] digits,
    output logic [2:0]              digit_count,
    output logic [4*MAX_DIGITS-1:0] entry_value,
    output logic [2:0]              entry_count,
    output logic                    entry_valid,
    output logic                    overflow
);

    localparam int          W        = 4 * MAX_DIGITS;
    localparam logic [15:0] CNT_LOAD = 16'(DEBOUNCE_CYCLES - 2);
    localparam logic [15:0] CNT_MAX  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]  MAXD     = 3'(MAX_DIGITS);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [3:0]  sync1;
    logic [3:0]  sync_code;
    logic [3:0]  sync_next;
    logic [15:0] db_cnt;
    logic [3:0]  stable_code;
    state_t      state;

    // Unused scanner codes look like "no key" from the second flop onward.
    assign sync_next = (sync1 > 4'd12) ? 4'd0 : sync1;

    // Two-flop synchroniser for the asynchronous scanner code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 4'd0;
            sync_code <= 4'd0;
        end else begin
            sync1     <= key_data;
            sync_code <= sync_next;
        end
    end

    // Debounce: count cycles the synchronised code holds; the counter reaching
    // DEBOUNCE_CYCLES-1 on this edge loads stable_code alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt      <= 16'd0;
            stable_code <= 4'd0;
        end else begin
            if (sync_next != sync_code) begin
                db_cnt <= 16'd0;
            end else if (db_cnt != CNT_MAX) begin
                db_cnt <= db_cnt + 16'd1;
            end
            if (sync_next == sync_code && db_cnt == CNT_LOAD) begin
                stable_code <= sync_code;
            end
        end
    end

    // Press FSM: one strobe per press, then wait for a full release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_pulse <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable_code != 4'd0) begin
                        key_pulse <= 1'b1;
                        key_code  <= (stable_code == 4'd11) ? 4'd0 : stable_code;
                        state     <= HELD;
                    end
                end
                HELD: begin
                    if (stable_code == 4'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entry buffer: acts on the press strobe, so updates appear one cycle after key_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_count <= 3'd0;
            entry_value <= '0;
            entry_count <= 3'd0;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
            if (key_pulse) begin
                if (key_code <= 4'd9) begin
                    if (digit_count < MAXD) begin
                        digits      <= (digits << 4) | W'(key_code);
                        digit_count <= digit_count + 3'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (key_code == 4'd10) begin
                    if (digit_count != 3'd0) begin
                        digits      <= digits >> 4;
                        digit_count <= digit_count - 3'd1;
                    end
                end else if (key_code == 4'd12) begin
                    if (digit_count != 3'd0) begin
                        entry_value <= digits;
                        entry_count <= digit_count;
                        entry_valid <= 1'b1;
                        digits      <= '0;
                        digit_count <= 3'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry with DEBOUNCE_CYCLES=4, MAX_DIGITS=4.
// Press codes are queued when a key is driven and popped by a monitor on each key_pulse.
// Vector table walks the buffer; hand sequences cover bounce, ignored codes and reset.
module tb_keypad_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  key_data;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic [15:0] entry_value;
    logic [2:0]  entry_count;
    logic        entry_valid;
    logic        overflow;

    keypad_entry #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .key_pulse  (key_pulse),
        .key_code   (key_code),
        .digits     (digits),
        .digit_count(digit_count),
        .entry_value(entry_value),
        .entry_count(entry_count),
        .entry_valid(entry_valid),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  code;
        logic [15:0] dig;
        logic [2:0]  cnt;
        logic        ov;
        logic        ev;
        logic [15:0] ev_val;
        logic [2:0]  ev_cnt;
    } vec_t;

    int         checks    = 0;
    int         failures  = 0;
    int         pulse_cnt = 0;
    logic [3:0] exp_q[$];
    logic       prev_kp = 1'b0;
    logic       prev_ov = 1'b0;
    logic       prev_ev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pop the expected code on every strobe, and flag back-to-back strobes.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst) begin
            if (key_pulse) begin
                pulse_cnt++;
                chk("key_pulse_consec", 32'(prev_kp), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got code %0d expected no pulse at %0t", key_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_code", 32'(key_code), 32'(e));
                end
            end
            if (overflow)    chk("overflow_consec", 32'(prev_ov), 32'd0);
            if (entry_valid) chk("entry_valid_consec", 32'(prev_ev), 32'd0);
        end
        prev_kp = key_pulse;
        prev_ov = overflow;
        prev_ev = entry_valid;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_key_pulse"},   32'(key_pulse),   32'd0);
        chk({tag, "_key_code"},    32'(key_code),    32'd0);
        chk({tag, "_digits"},      32'(digits),      32'd0);
        chk({tag, "_digit_count"}, 32'(digit_count), 32'd0);
        chk({tag, "_entry_value"}, 32'(entry_value), 32'd0);
        chk({tag, "_entry_count"}, 32'(entry_count), 32'd0);
        chk({tag, "_entry_valid"}, 32'(entry_valid), 32'd0);
        chk({tag, "_overflow"},    32'(overflow),    32'd0);
    endtask

    // One press: exact strobe latency, buffer state the cycle after, then release.
    task automatic apply(input vec_t v);
        key_data = v.key;
        exp_q.push_back(v.code);
        repeat (5) @(negedge clk);
        chk("pulse_early", 32'(key_pulse), 32'd0);
        @(negedge clk);
        chk("pulse_latency", 32'(key_pulse), 32'd1);
        @(negedge clk);
        chk("digits",      32'(digits),      32'(v.dig));
        chk("digit_count", 32'(digit_count), 32'(v.cnt));
        chk("overflow",    32'(overflow),    32'(v.ov));
        chk("entry_valid", 32'(entry_valid), 32'(v.ev));
        chk("entry_value", 32'(entry_value), 32'(v.ev_val));
        chk("entry_count", 32'(entry_count), 32'(v.ev_cnt));
        key_data = 4'd0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   pc0;

        //            key    code   digits     cnt   ov    ev    ev_val     ev_cnt
        vecs.push_back('{4'd1,  4'd1,  16'h0001, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{4'd11, 4'd0,  16'h0010, 3'd2, 1'b0, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{4'd5,  4'd5,  16'h0105, 3'd3, 1'b0, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{4'd12, 4'd12, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0105, 3'd3});
        vecs.push_back('{4'd1,  4'd1,  16'h0001, 3'd1, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd2,  4'd2,  16'h0012, 3'd2, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd3,  4'd3,  16'h0123, 3'd3, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd4,  4'd4,  16'h1234, 3'd4, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd9,  4'd9,  16'h1234, 3'd4, 1'b1, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd10, 4'd10, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd10, 4'd10, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd10, 4'd10, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd10, 4'd10, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd10, 4'd10, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd4,  4'd4,  16'h0004, 3'd1, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd2,  4'd2,  16'h0042, 3'd2, 1'b0, 1'b0, 16'h0105, 3'd3});
        vecs.push_back('{4'd12, 4'd12, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0042, 3'd2});
        vecs.push_back('{4'd12, 4'd12, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0042, 3'd2});

        rst      = 1'b1;
        key_data = 4'd0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_all_zero("after_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Contact bounce: 7/0 toggling every 2 cycles must never be accepted.
        pc0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            key_data = 4'd7;
            repeat (2) @(negedge clk);
            key_data = 4'd0;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
        key_data = 4'd7;
        exp_q.push_back(4'd7);
        repeat (12) @(negedge clk);
        chk("bounce_one_pulse", 32'(pulse_cnt - pc0), 32'd1);
        chk("bounce_digits", 32'(digits), 32'h0007);
        chk("bounce_count",  32'(digit_count), 32'd1);
        key_data = 4'd0;
        repeat (10) @(negedge clk);

        // Codes 13-15 read as no key.
        pc0 = pulse_cnt;
        key_data = 4'd14;
        repeat (12) @(negedge clk);
        key_data = 4'd0;
        repeat (10) @(negedge clk);
        chk("code14_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
        chk("code14_digits",   32'(digits), 32'h0007);

        // Reset in the middle of debouncing key 3 discards press and buffer.
        pc0 = pulse_cnt;
        key_data = 4'd3;
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        key_data = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_reset");
        repeat (12) @(negedge clk);
        chk("mid_reset_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
        chk("mid_reset_digits",   32'(digits), 32'd0);

        v = '{4'd3, 4'd3, 16'h0003, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0};
        apply(v);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumes the 4-bit key code from the 4x3 keypad scanner and turns it into clean press events.
- Processing chain: synchronise the code, debounce it, then detect each press exactly once.
- Assembles pressed digits into a multi-digit BCD entry buffer. '*' acts as backspace; '#' commits the entry to downstream logic (display/compare stage) with a one-cycle valid strobe.

Parameters:
- DEBOUNCE_CYCLES, 20000: clk cycles a synchronised code must stay unchanged before it is accepted (range 2..65535).
- MAX_DIGITS, 4: entry buffer depth in BCD digits (range 1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_data  in  4  scanner code: 0 none, 1-9 digit, 10 '*', 11 digit '0', 12 '#', 13-15 treated as 0
- key_pulse  out  1  one-cycle strobe per accepted press
- key_code  out  4  normalised code of the last press, held between presses: 0-9 digit value, 10 '*', 12 '#'
- digits  out  4*MAX_DIGITS  live buffer; LSD is bits [3:0]; unused positions are 0
- digit_count  out  3  number of valid digits in the buffer
- entry_value  out  4*MAX_DIGITS  last committed buffer, held until the next commit
- entry_count  out  3  digit count of the last commit
- entry_valid  out  1  one-cycle strobe on commit
- overflow  out  1  one-cycle strobe when a digit is pressed while the buffer is full

Behaviour:
- Reset: all outputs, the synchroniser, the debounce counter, the stable code and the FSM clear to 0/IDLE immediately on rst.
- Synchroniser: key_data passes through a 2-flop synchroniser. Codes 13-15 map to 0 at the synchroniser output.
- Debounce:
  - A 16-bit counter clears whenever the synchronised code differs from its previous-cycle value; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable_code takes the synchronised value.
  - Acceptance latency from a key_data change is 2 + DEBOUNCE_CYCLES cycles.
- Press FSM:
  - IDLE: when stable_code is nonzero, assert key_pulse for one cycle, latch key_code, then go to HELD. Code 11 is normalised to digit value 0.
  - HELD: wait for stable_code == 0, then return to IDLE. A nonzero→different-nonzero change while in HELD produces no event (release is required).
- Buffer actions are registered on the cycle of key_pulse and become visible the following cycle:
  - Digit, count < MAX_DIGITS: digits shift left one nibble; the new digit enters [3:0]; digit_count+1.
  - Digit, count == MAX_DIGITS: buffer unchanged; overflow pulses one cycle.
  - '*', count > 0: digits shift right one nibble with 0 filled at the top; digit_count-1.
  - '*', count == 0: no change.
  - '#', count > 0: entry_value ← digits, entry_count ← digit_count, entry_valid pulses one cycle; buffer and digit_count clear in the same cycle.
  - '#', count == 0: ignored; no entry_valid.
- At most one action per press, and key_pulse/overflow/entry_valid are never high for two consecutive cycles.
- rst asserted mid-debounce or mid-hold discards the pending press and the buffer. entry_value is also cleared.

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGITS=4):
- Press 1, release; press 11 (digit '0'), release; press 5, release → three key_pulse strobes; key_code 1,0,5; digits=0x0105; digit_count=3. Each pulse occurs 6 cycles after its key_data change.
- Toggle key_data between 7 and 0 every 2 cycles for 20 cycles, then hold 7 → exactly one key_pulse, code 7.
- Enter 1,2,3,4 then press 9 → digits=0x1234, digit_count=4; overflow pulses once; buffer unchanged.
- Buffer 0x0123, press '*' twice → 0x0012 then 0x0001; digit_count 2 then 1. '*' at count 0 leaves 0x0000 with no other change.
- Buffer 0x0042, press '#' → entry_valid for one cycle; entry_value=0x0042; entry_count=2; digits=0, digit_count=0. An immediate second '#' produces no entry_valid.
- Hold key 3 and assert rst for 1 cycle mid-debounce → no key_pulse and all outputs 0. After release and a fresh press of 3, a normal pulse occurs.
